octet_align_ctrl: RTL and testbench
===================================

Name: octet_align_ctrl

Overview:
- Sequencer that finds, verifies and tracks octet alignment for one JESD204B lane.
- Watches the raw, unaligned post-8b/10b octet stream. Sets the octet alignment index from the position of the first /R/ (K28.0) character after CGS.
- Confirms the index against the positions of /A/ (K28.3) multiframe-end characters, then keeps monitoring them while locked.
- Drives the index input of the lane's octet aligner and reports lock status to the link FSM.

Parameters:
PARALLEL_OCTETS, 4, octets per input word (power of two, 2..8)
DATA_WIDTH, 32, raw data width, must equal PARALLEL_OCTETS*8
LOCK_COUNT, 4, consecutive correctly placed /A/ needed to enter LOCKED (>=1)
ERR_THRESH, 3, misplaced /A/ in LOCKED before realignment (>=1)
TIMEOUT_CYCLES, 1024, max VERIFY dwell without reaching LOCK_COUNT

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  link FSM permits alignment; low forces IDLE
raw_data_i  in  DATA_WIDTH  unaligned octets; octet i is bits [i*8+:8], octet 0 is earliest
raw_char_is_k28_i  in  PARALLEL_OCTETS  per-octet K-character flag, same alignment as raw_data_i
octet_align_idx_o  out  3  alignment offset to the octet aligner; upper unused bits are 0
locked_o  out  1  high only in LOCKED
align_err_o  out  1  one-cycle pulse on any misplaced /A/ (VERIFY or LOCKED)
state_o  out  2  IDLE=0, SEARCH=1, VERIFY=2, LOCKED=3
relock_cnt_o  out  8  count of LOCKED->SEARCH transitions, saturates at 255

Behaviour:
- Reset (rst_i=1, takes priority over everything):
  - state=IDLE, octet_align_idx_o=0, locked_o=0, align_err_o=0, relock_cnt_o=0.
  - All internal counters cleared.
- Character detection (combinational, on the raw word):
  - /R/ at octet i: raw_char_is_k28_i[i]=1 and octet value 0x1C.
  - /A/ at octet i: raw_char_is_k28_i[i]=1 and octet value 0x7C.
  - If several octets match in one word, the lowest index is used.
- Expected /A/ position: exp = (idx + PARALLEL_OCTETS - 1) mod PARALLEL_OCTETS, where idx is the registered octet_align_idx_o.
- IDLE:
  - enable_i=1 -> SEARCH next cycle.
  - octet_align_idx_o holds its last value.
- SEARCH:
  - On a word containing /R/ at lowest index p: octet_align_idx_o <= p and state <= VERIFY, both taking effect the next cycle.
  - Match counter and timeout counter cleared on entry to VERIFY.
  - /A/ is ignored in SEARCH.
- VERIFY:
  - /A/ at exp: match counter +1; on reaching LOCK_COUNT -> LOCKED, with locked_o=1 from the next cycle.
  - /A/ at any other position: align_err_o pulses that cycle, state -> SEARCH.
  - Timeout counter increments every cycle; at TIMEOUT_CYCLES-1 with no lock -> SEARCH.
  - A correct /A/ in the same cycle as the timeout wins: it is counted, and if it completes LOCK_COUNT the block goes to LOCKED.
  - /R/ is ignored in VERIFY; the index does not change.
- LOCKED:
  - /A/ at exp clears the error counter.
  - Misplaced /A/: align_err_o pulses and the error counter +1.
  - Error counter reaching ERR_THRESH: -> SEARCH, locked_o=0 next cycle, relock_cnt_o +1 (saturating).
  - octet_align_idx_o is frozen while LOCKED.
- enable_i=0 in any state:
  - -> IDLE next cycle; locked_o=0 next cycle; counters cleared; idx held.
  - relock_cnt_o is not incremented.
  - Takes priority over any same-cycle transition.
- Latency:
  - Index update, state change and locked_o are all registered: one cycle after the deciding word.
  - align_err_o is registered: asserted in the cycle after the offending word, width exactly 1 cycle.
- Outputs are glitch-free registers; state_o is a direct state register view.

Test Plan:
- Reset, enable_i=1, K28.5 words, then a word with /R/ (0x1C, k=1) at octet 2 -> next cycle idx=2, state=VERIFY.
- idx=2, 4 words with /A/ (0x7C, k=1) at octet 1, LOCK_COUNT=4 -> locked_o=1 one cycle after the 4th, state=3.
- VERIFY with idx=0, /A/ at octet 2 -> align_err_o single pulse, state=SEARCH, locked_o stays 0.
- LOCKED idx=1: misplaced /A/ twice, correct /A/, misplaced 3 times (ERR_THRESH=3) -> 5 align_err_o pulses, no unlock until the 3rd consecutive error, then relock_cnt_o=1, state=SEARCH.
- VERIFY with no /A/ for 1024 cycles -> SEARCH at cycle 1024; repeat with a correct /A/ on the timeout cycle -> match counted, no timeout.
- LOCKED, drop enable_i -> IDLE and locked_o=0 next cycle, relock_cnt_o unchanged, idx held. Assert rst_i mid-VERIFY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/octet_align_ctrl.sv
// Octet alignment sequencer for one JESD204B lane.
// Finds the index from /R/, verifies and tracks it with /A/.
module octet_align_ctrl #(
    parameter int PARALLEL_OCTETS = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int LOCK_COUNT      = 4,
    parameter int ERR_THRESH      = 3,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       enable_i,
    input  logic [DATA_WIDTH-1:0]      raw_data_i,
    input  logic [PARALLEL_OCTETS-1:0] raw_char_is_k28_i,
    output logic [2:0]                 octet_align_idx_o,
    output logic                       locked_o,
    output logic                       align_err_o,
    output logic [1:0]                 state_o,
    output logic [7:0]                 relock_cnt_o
);

    localparam int PW = $clog2(PARALLEL_OCTETS);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(ERR_THRESH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_THRESH - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_VERIFY = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [MW-1:0] match_q, match_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [EW-1:0] err_q, err_d;
    logic [7:0]    relock_q, relock_d;
    logic          aerr_q, aerr_d;
    logic          locked_q, locked_d;

    logic          r_hit, a_hit;
    logic [PW-1:0] r_pos, a_pos;
    logic [PW-1:0] exp_pos;
    logic          a_good, a_bad;

    // Lowest-index /R/ and /A/ in the raw word (descending scan, last hit wins)
    always_comb begin
        r_hit = 1'b0;
        a_hit = 1'b0;
        r_pos = '0;
        a_pos = '0;
        for (int i = PARALLEL_OCTETS - 1; i >= 0; i--) begin
            if (raw_char_is_k28_i[i] && raw_data_i[i*8+:8] == 8'h1C) begin
                r_hit = 1'b1;
                r_pos = PW'(i);
            end
            if (raw_char_is_k28_i[i] && raw_data_i[i*8+:8] == 8'h7C) begin
                a_hit = 1'b1;
                a_pos = PW'(i);
            end
        end
    end

    // /A/ must land one octet before the /R/ position (mod lane width)
    assign exp_pos = idx_q[PW-1:0] + {PW{1'b1}};
    assign a_good  = a_hit && (a_pos == exp_pos);
    assign a_bad   = a_hit && (a_pos != exp_pos);

    // Next-state, counters and error pulse
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        match_d  = match_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        relock_d = relock_q;
        aerr_d   = 1'b0;
        if (!enable_i) begin
            state_d = S_IDLE;
            match_d = '0;
            tmo_d   = '0;
            err_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_SEARCH;
                    match_d = '0;
                    tmo_d   = '0;
                    err_d   = '0;
                end
                S_SEARCH: begin
                    if (r_hit) begin
                        idx_d   = 3'(r_pos);
                        state_d = S_VERIFY;
                        match_d = '0;
                        tmo_d   = '0;
                    end
                end
                S_VERIFY: begin
                    if (tmo_q != TMO_LAST) begin
                        tmo_d = tmo_q + 1'b1;
                    end
                    if (a_good) begin
                        if (match_q == MATCH_LAST) begin
                            state_d = S_LOCKED;
                            err_d   = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else if (a_bad) begin
                        aerr_d  = 1'b1;
                        state_d = S_SEARCH;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = S_SEARCH;
                    end
                end
                S_LOCKED: begin
                    if (a_good) begin
                        err_d = '0;
                    end else if (a_bad) begin
                        aerr_d = 1'b1;
                        if (err_q == ERR_LAST) begin
                            state_d = S_SEARCH;
                            err_d   = '0;
                            if (relock_q != 8'hFF) begin
                                relock_d = relock_q + 8'd1;
                            end
                        end else begin
                            err_d = err_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        locked_d = (state_d == S_LOCKED);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            match_q  <= '0;
            tmo_q    <= '0;
            err_q    <= '0;
            relock_q <= '0;
            aerr_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            match_q  <= match_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            relock_q <= relock_d;
            aerr_q   <= aerr_d;
            locked_q <= locked_d;
        end
    end

    assign octet_align_idx_o = idx_q;
    assign locked_o          = locked_q;
    assign align_err_o       = aerr_q;
    assign state_o           = state_q;
    assign relock_cnt_o      = relock_q;

endmodule

// File: tb/tb_octet_align_ctrl.sv
// Scoreboard bench for octet_align_ctrl.
// Stimulus pushes expected outputs; a monitor pops and checks.
module tb_octet_align_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [31:0] raw_data_i = 32'hBCBCBCBC;
    logic [3:0]  raw_char_is_k28_i = 4'hF;
    logic [2:0]  octet_align_idx_o;
    logic        locked_o;
    logic        align_err_o;
    logic [1:0]  state_o;
    logic [7:0]  relock_cnt_o;

    typedef struct packed {
        logic [1:0] st;
        logic [2:0] idx;
        logic       lk;
        logic       er;
        logic [7:0] rc;
    } exp_t;

    exp_t sb[$];
    int   n_eval = 0;
    int   n_fail = 0;
    int   step = 0;

    always #5 clk = ~clk;

    octet_align_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .enable_i          (enable_i),
        .raw_data_i        (raw_data_i),
        .raw_char_is_k28_i (raw_char_is_k28_i),
        .octet_align_idx_o (octet_align_idx_o),
        .locked_o          (locked_o),
        .align_err_o       (align_err_o),
        .state_o           (state_o),
        .relock_cnt_o      (relock_cnt_o)
    );

    task automatic drv(input logic rst, input logic en,
                       input logic [3:0] rm, input logic [3:0] am,
                       input logic [3:0] kc,
                       input logic [1:0] es, input logic [2:0] ei,
                       input logic el, input logic ee,
                       input logic [7:0] ec);
        exp_t e;
        @(negedge clk);
        rst_i = rst;
        enable_i = en;
        for (int i = 0; i < 4; i++) begin
            raw_data_i[i*8+:8] = rm[i] ? 8'h1C : (am[i] ? 8'h7C : 8'hBC);
            raw_char_is_k28_i[i] = ~kc[i];
        end
        e.st = es;
        e.idx = ei;
        e.lk = el;
        e.er = ee;
        e.rc = ec;
        sb.push_back(e);
    endtask

    task automatic w(input logic [3:0] rm, input logic [3:0] am,
                     input logic [1:0] es, input logic [2:0] ei,
                     input logic el, input logic ee,
                     input logic [7:0] ec);
        drv(1'b0, 1'b1, rm, am, 4'h0, es, ei, el, ee, ec);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                step++;
                n_eval++;
                if ({state_o, octet_align_idx_o, locked_o,
                     align_err_o, relock_cnt_o} !== e) begin
                    n_fail++;
                    $display("FAIL step%0d: got st=%0d idx=%0d lk=%0b er=%0b rc=%0d, want st=%0d idx=%0d lk=%0b er=%0b rc=%0d",
                             step, state_o, octet_align_idx_o, locked_o,
                             align_err_o, relock_cnt_o, e.st, e.idx,
                             e.lk, e.er, e.rc);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // reset
        drv(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
        drv(1, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
        // enable, search over K28.5, /R/ at octet 2
        w(4'h0, 4'h0, 1, 0, 0, 0, 0);
        w(4'h0, 4'h0, 1, 0, 0, 0, 0);
        w(4'h0, 4'h0, 1, 0, 0, 0, 0);
        drv(0, 1, 4'b0001, 4'h0, 4'b0001, 1, 0, 0, 0, 0);
        w(4'b0100, 4'h0, 2, 2, 0, 0, 0);
        // /A/ at octet 1 four times -> LOCKED
        w(4'h0, 4'b0010, 2, 2, 0, 0, 0);
        w(4'h0, 4'b0010, 2, 2, 0, 0, 0);
        w(4'h0, 4'b0010, 2, 2, 0, 0, 0);
        w(4'h0, 4'b0010, 3, 2, 1, 0, 0);
        w(4'b0001, 4'h0, 3, 2, 1, 0, 0);
        // drop enable from LOCKED
        drv(0, 0, 4'h0, 4'h0, 4'h0, 0, 2, 0, 0, 0);
        w(4'h0, 4'h0, 1, 2, 0, 0, 0);
        // /R/ at 0, then /R/ ignored in VERIFY
        w(4'b0001, 4'h0, 2, 0, 0, 0, 0);
        w(4'b1000, 4'h0, 2, 0, 0, 0, 0);
        // misplaced /A/ in VERIFY
        w(4'h0, 4'b0100, 1, 0, 0, 1, 0);
        w(4'h0, 4'h0, 1, 0, 0, 0, 0);
        // lowest /R/ wins; lock at idx 1 with /A/ at 0
        w(4'b1010, 4'h0, 2, 1, 0, 0, 0);
        w(4'h0, 4'b0001, 2, 1, 0, 0, 0);
        w(4'h0, 4'b0001, 2, 1, 0, 0, 0);
        w(4'h0, 4'b0001, 2, 1, 0, 0, 0);
        w(4'h0, 4'b0001, 3, 1, 1, 0, 0);
        // errors in LOCKED: 2 bad, 1 good, 3 bad
        w(4'h0, 4'b0100, 3, 1, 1, 1, 0);
        w(4'h0, 4'b0100, 3, 1, 1, 1, 0);
        w(4'h0, 4'b0001, 3, 1, 1, 0, 0);
        w(4'h0, 4'b0100, 3, 1, 1, 1, 0);
        w(4'h0, 4'b1000, 3, 1, 1, 1, 0);
        w(4'h0, 4'b0100, 1, 1, 0, 1, 1);
        w(4'h0, 4'h0, 1, 1, 0, 0, 1);
        // VERIFY timeout after 1024 cycles
        w(4'b1000, 4'h0, 2, 3, 0, 0, 1);
        for (int i = 0; i < 1023; i++) w(4'h0, 4'h0, 2, 3, 0, 0, 1);
        w(4'h0, 4'h0, 1, 3, 0, 0, 1);
        // correct /A/ on the timeout cycle is counted
        w(4'b1000, 4'h0, 2, 3, 0, 0, 1);
        for (int i = 0; i < 1023; i++) w(4'h0, 4'h0, 2, 3, 0, 0, 1);
        w(4'h0, 4'b0100, 2, 3, 0, 0, 1);
        w(4'h0, 4'b0100, 2, 3, 0, 0, 1);
        w(4'h0, 4'b0100, 2, 3, 0, 0, 1);
        w(4'h0, 4'b0100, 3, 3, 1, 0, 1);
        // drop enable: relock count and idx held
        drv(0, 0, 4'h0, 4'b0001, 4'h0, 0, 3, 0, 0, 1);
        w(4'h0, 4'h0, 1, 3, 0, 0, 1);
        w(4'b0100, 4'h0, 2, 2, 0, 0, 1);
        // reset mid-VERIFY
        drv(1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0);
        w(4'h0, 4'h0, 1, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        n_eval++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_eval, n_fail);
        $finish;
    end

endmodule
